// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Autobaud FSM encoding plus the sync-character measurement constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HIGH,
        WAIT_START,
        MEASURE,
        CHECK,
        WAIT_STOP
    } autobaud_fsm_t;

    // Falling edges in a 0x55 frame: start edge plus four data edges, 8 bit times apart
    localparam logic [2:0] AB_NFALL = 3'd5;
    localparam int         AB_SHIFT = 3;

endpackage

// File: rtl/uart_sync_edge.sv
// rtl/uart_sync_edge.sv - 2-flop synchronizer with falling-edge detect
// Flops reset to 1 so an idle (marking) line never produces a spurious edge.
module uart_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign fall = prev & ~sync;

endmodule

// File: rtl/uart_autobaud.sv
// rtl/uart_autobaud.sv - baud-rate detector timing a 0x55 sync character
// Measures 8 bit times between the 1st and 5th falling edges and derives the receiver divider.
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int          CNT_W   = 20,
    parameter logic [15:0] DEF_DIV = 16'd103,
    parameter logic [15:0] MIN_DIV = 16'd3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             rx_i,
    input  logic             cfg_en_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] cfg_timeout_i,
    output logic [15:0]      div_o,
    output logic             rx_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic             err_clr_i
);

    autobaud_fsm_t    state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] iv;
    logic [CNT_W-1:0] ref_iv;
    logic [CNT_W-1:0] tmo;
    logic [2:0]       nfall;
    logic [15:0]      res;

    logic             sync;
    logic             fall;
    logic [CNT_W-1:0] ivl;
    logic [CNT_W-1:0] diff;
    logic [CNT_W:0]   q;
    logic [CNT_W:0]   qm1;
    logic             err_raise;

    uart_sync_edge u_sync (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .async_in (rx_i),
        .sync     (sync),
        .fall     (fall)
    );

    // iv restarts the cycle after each edge, so the interval length in clocks is iv+1
    assign ivl  = iv + 1'b1;
    assign diff = (ivl > ref_iv) ? (ivl - ref_iv) : (ref_iv - ivl);
    assign q    = ({1'b0, cnt} + (CNT_W+1)'(4)) >> AB_SHIFT;
    assign qm1  = q - 1'b1;

    always_comb begin
        err_raise = 1'b0;
        if (cfg_en_i && !abort_i) begin
            case (state)
                WAIT_START: err_raise = (tmo >= cfg_timeout_i);
                MEASURE: err_raise = (tmo >= cfg_timeout_i) || (cnt == '1) ||
                                     (fall && (nfall >= 3'd2) && (nfall <= 3'd4) &&
                                      (diff > (ref_iv >> AB_SHIFT)));
                CHECK: err_raise = (qm1 < {{(CNT_W-15){1'b0}}, MIN_DIV}) ||
                                   (qm1 > {{(CNT_W-15){1'b0}}, 16'hFFFF});
                default: err_raise = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            cnt    <= '0;
            iv     <= '0;
            ref_iv <= '0;
            tmo    <= '0;
            nfall  <= '0;
            res    <= DEF_DIV;
            div_o  <= DEF_DIV;
            done_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (err_raise) begin
                err_o <= 1'b1;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end

            if (!cfg_en_i) begin
                state  <= IDLE;
                cnt    <= '0;
                iv     <= '0;
                ref_iv <= '0;
                tmo    <= '0;
                nfall  <= '0;
            end else if (abort_i && state != IDLE) begin
                state <= IDLE;
            end else if (err_raise) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i && !abort_i) state <= WAIT_HIGH;
                    end
                    WAIT_HIGH: begin
                        if (sync) begin
                            state <= WAIT_START;
                            tmo   <= '0;
                        end
                    end
                    WAIT_START: begin
                        tmo <= tmo + 1'b1;
                        if (fall) begin
                            state <= MEASURE;
                            cnt   <= '0;
                            iv    <= '0;
                            tmo   <= '0;
                            nfall <= 3'd1;
                        end
                    end
                    MEASURE: begin
                        cnt <= cnt + 1'b1;
                        iv  <= iv + 1'b1;
                        tmo <= tmo + 1'b1;
                        if (fall) begin
                            nfall <= nfall + 1'b1;
                            iv    <= '0;
                            if (nfall == 3'd1) ref_iv <= ivl;
                            if (nfall == (AB_NFALL - 3'd1)) state <= CHECK;
                        end
                    end
                    CHECK: begin
                        res   <= qm1[15:0];
                        state <= WAIT_STOP;
                    end
                    WAIT_STOP: begin
                        if (sync) begin
                            div_o  <= res;
                            done_o <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy_o  = (state != IDLE);
    assign rx_en_o = cfg_en_i & ~busy_o;

endmodule
